rv_wb_arbiter: RTL and testbench

- Parametrised N-port Wishbone classic master arbiter.
- Replaces the fixed two-way combinational instruction/data mux at the SoC top with registered, protocol-correct bus cycles: cyc/stb only during transfers.
- Adds selectable fixed-priority or round-robin arbitration, bus lock for atomic sequences, and a per-transfer timeout that returns an error.
- Sits between the core's fetch/data/debug request ports and the system Wishbone bus.

---
 rtl/rv_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_rv_wb_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_wb_arbiter.sv
// rv_wb_arbiter
// N-port Wishbone classic master arbiter. It grants one requesting port at a
// time and runs a registered bus cycle on its behalf. cyc/stb are asserted
// only while a transfer (or a locked sequence) is in progress.
//
// Ports
//   i_clk, i_reset   clock; synchronous active-high reset
//   i_req/i_lock/i_we                 per-port request, bus lock, write enable
//   i_addr/i_wdata/i_sel              flattened per-port transfer fields
//   o_ack/o_err/o_rdata               per-port completion pulses, read data
//   o_busy                            arbiter is not idle
//   o_wb_*                            Wishbone master signals
//   i_wb_dat/i_wb_ack/i_wb_err        Wishbone slave response
module rv_wb_arbiter #(
    parameter int N_PORTS        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [N_PORTS-1:0]               i_req,
    input  logic [N_PORTS-1:0]               i_lock,
    input  logic [N_PORTS-1:0]               i_we,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]    i_addr,
    input  logic [N_PORTS*DATA_WIDTH-1:0]    i_wdata,
    input  logic [N_PORTS*DATA_WIDTH/8-1:0]  i_sel,
    output logic [N_PORTS-1:0]               o_ack,
    output logic [N_PORTS-1:0]               o_err,
    output logic [DATA_WIDTH-1:0]            o_rdata,
    output logic                             o_busy,
    output logic [ADDR_WIDTH-1:0]            o_wb_adr,
    output logic [DATA_WIDTH-1:0]            o_wb_dat,
    input  logic [DATA_WIDTH-1:0]            i_wb_dat,
    output logic                             o_wb_we,
    output logic [DATA_WIDTH/8-1:0]          o_wb_sel,
    output logic                             o_wb_stb,
    output logic                             o_wb_cyc,
    input  logic                             i_wb_ack,
    input  logic                             i_wb_err
);
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [N_PORTS-1:0] PORT0_BIT = N_PORTS'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_LOCKED} state_t;

    state_t                  state_reg, state_next;
    logic [PTR_W-1:0]        grant_reg, grant_next;
    logic [PTR_W-1:0]        rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]        tmo_cnt_reg, tmo_cnt_next;
    logic [N_PORTS-1:0]      ack_reg, ack_next, err_reg, err_next;
    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
    logic                    busy_reg, busy_next;
    logic [ADDR_WIDTH-1:0]   adr_reg, adr_next;
    logic [DATA_WIDTH-1:0]   dat_reg, dat_next;
    logic                    we_reg, we_next;
    logic [SEL_W-1:0]        sel_reg, sel_next;
    logic                    stb_reg, stb_next, cyc_reg, cyc_next;

    // Per-port views of the flattened request fields.
    logic [ADDR_WIDTH-1:0]   port_adr [N_PORTS];
    logic [DATA_WIDTH-1:0]   port_dat [N_PORTS];
    logic [SEL_W-1:0]        port_sel [N_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_unpack
            assign port_adr[gi] = i_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign port_dat[gi] = i_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign port_sel[gi] = i_sel[gi*SEL_W +: SEL_W];
        end
    endgenerate

    // Fixed priority: scanning downwards leaves the lowest requesting index.
    logic [PTR_W-1:0] fp_idx;
    always_comb begin
        fp_idx = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (i_req[PTR_W'(k)]) fp_idx = PTR_W'(k);
        end
    end

    // Round robin: candidates ptr+1 .. ptr+N (mod N); scanning the offsets
    // downwards leaves the nearest requester after the pointer.
    logic [PTR_W-1:0] rr_idx;
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = N_PORTS; k >= 1; k--) begin
            cand     = (int'(rr_ptr_reg) + k) % N_PORTS;
            cand_idx = PTR_W'(cand);
            if (i_req[cand_idx]) rr_idx = cand_idx;
        end
    end

    logic [PTR_W-1:0] arb_idx;
    assign arb_idx = (ARB_MODE == 1) ? rr_idx : fp_idx;

    // The counter advances once per waiting bus cycle and the compare is
    // against TIMEOUT_CYCLES, so a silent slave gets its error
    // TIMEOUT_CYCLES+1 cycles after stb first goes high.
    logic timeout_hit;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        logic             load_port;
        logic             finish;
        logic [PTR_W-1:0] load_idx;
        state_next   = state_reg;
        grant_next   = grant_reg;
        rr_ptr_next  = rr_ptr_reg;
        tmo_cnt_next = tmo_cnt_reg;
        ack_next     = '0;
        err_next     = '0;
        rdata_next   = '0;
        adr_next     = adr_reg;
        dat_next     = dat_reg;
        we_next      = we_reg;
        sel_next     = sel_reg;
        stb_next     = stb_reg;
        cyc_next     = cyc_reg;
        load_port    = 1'b0;
        finish       = 1'b0;
        load_idx     = grant_reg;

        case (state_reg)
            ST_IDLE: begin
                if (|i_req) begin
                    load_port  = 1'b1;
                    load_idx   = arb_idx;
                    grant_next = arb_idx;
                    if (ARB_MODE == 1) rr_ptr_next = arb_idx;
                end
            end
            ST_BUS: begin
                // Ack wins over a simultaneous err or timeout.
                if (i_wb_ack) begin
                    ack_next   = PORT0_BIT << grant_reg;
                    rdata_next = i_wb_dat;
                    finish     = 1'b1;
                end else if (i_wb_err || timeout_hit) begin
                    err_next   = PORT0_BIT << grant_reg;
                    finish     = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
                end
                if (finish) begin
                    stb_next     = 1'b0;
                    tmo_cnt_next = '0;
                    if (i_lock[grant_reg]) begin
                        state_next = ST_LOCKED;
                        cyc_next   = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        cyc_next   = 1'b0;
                    end
                end
            end
            ST_LOCKED: begin
                // Only the lock owner is served; everyone else waits.
                if (i_req[grant_reg]) begin
                    load_port = 1'b1;
                end else if (!i_lock[grant_reg]) begin
                    state_next = ST_IDLE;
                    cyc_next   = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                stb_next   = 1'b0;
                cyc_next   = 1'b0;
            end
        endcase

        if (load_port) begin
            adr_next     = port_adr[load_idx];
            dat_next     = port_dat[load_idx];
            sel_next     = port_sel[load_idx];
            we_next      = i_we[load_idx];
            stb_next     = 1'b1;
            cyc_next     = 1'b1;
            tmo_cnt_next = '0;
            state_next   = ST_BUS;
        end

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= '0;
            rr_ptr_reg  <= PTR_W'(N_PORTS - 1);
            tmo_cnt_reg <= '0;
            ack_reg     <= '0;
            err_reg     <= '0;
            rdata_reg   <= '0;
            busy_reg    <= 1'b0;
            adr_reg     <= '0;
            dat_reg     <= '0;
            we_reg      <= 1'b0;
            sel_reg     <= '0;
            stb_reg     <= 1'b0;
            cyc_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            rr_ptr_reg  <= rr_ptr_next;
            tmo_cnt_reg <= tmo_cnt_next;
            ack_reg     <= ack_next;
            err_reg     <= err_next;
            rdata_reg   <= rdata_next;
            busy_reg    <= busy_next;
            adr_reg     <= adr_next;
            dat_reg     <= dat_next;
            we_reg      <= we_next;
            sel_reg     <= sel_next;
            stb_reg     <= stb_next;
            cyc_reg     <= cyc_next;
        end
    end

    assign o_ack    = ack_reg;
    assign o_err    = err_reg;
    assign o_rdata  = rdata_reg;
    assign o_busy   = busy_reg;
    assign o_wb_adr = adr_reg;
    assign o_wb_dat = dat_reg;
    assign o_wb_we  = we_reg;
    assign o_wb_sel = sel_reg;
    assign o_wb_stb = stb_reg;
    assign o_wb_cyc = cyc_reg;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Testbench for rv_wb_arbiter. Two instances with three ports each:
//   instance 0: fixed priority, TIMEOUT_CYCLES = 8
//   instance 1: round robin,    TIMEOUT_CYCLES = 256
module tb_rv_wb_arbiter;
    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst       [2];
    logic [NP-1:0]     req       [2];
    logic [NP-1:0]     lock      [2];
    logic [NP-1:0]     we        [2];
    logic [NP*AW-1:0]  addr      [2];
    logic [NP*DW-1:0]  wdata     [2];
    logic [NP*SW-1:0]  sel       [2];
    logic [NP-1:0]     ack_o     [2];
    logic [NP-1:0]     err_o     [2];
    logic [DW-1:0]     rdata     [2];
    logic              busy      [2];
    logic [AW-1:0]     wb_adr    [2];
    logic [DW-1:0]     wb_dat    [2];
    logic [DW-1:0]     wb_dat_in [2];
    logic              wb_we     [2];
    logic [SW-1:0]     wb_sel    [2];
    logic              wb_stb    [2];
    logic              wb_cyc    [2];
    logic              wb_ack    [2];
    logic              wb_err    [2];

    int checks   = 0;
    int failures = 0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            rv_wb_arbiter #(
                .N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                .ARB_MODE(gi), .TIMEOUT_CYCLES(gi == 0 ? 8 : 256)
            ) dut (
                .i_clk(clk), .i_reset(rst[gi]),
                .i_req(req[gi]), .i_lock(lock[gi]), .i_we(we[gi]),
                .i_addr(addr[gi]), .i_wdata(wdata[gi]), .i_sel(sel[gi]),
                .o_ack(ack_o[gi]), .o_err(err_o[gi]), .o_rdata(rdata[gi]),
                .o_busy(busy[gi]),
                .o_wb_adr(wb_adr[gi]), .o_wb_dat(wb_dat[gi]), .i_wb_dat(wb_dat_in[gi]),
                .o_wb_we(wb_we[gi]), .o_wb_sel(wb_sel[gi]),
                .o_wb_stb(wb_stb[gi]), .o_wb_cyc(wb_cyc[gi]),
                .i_wb_ack(wb_ack[gi]), .i_wb_err(wb_err[gi])
            );
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int d, input int k, input logic [AW-1:0] a,
                            input logic w, input logic [DW-1:0] dat);
        addr[d][k*AW +: AW]  = a;
        we[d][k]             = w;
        wdata[d][k*DW +: DW] = dat;
        sel[d][k*SW +: SW]   = '1;
    endtask

    task automatic wait_stb(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (wb_stb[d]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({ack_o[d], err_o[d], busy[d], wb_we[d], wb_stb[d], wb_cyc[d]} !== 10'b0) begin
                failures++;
                $display("FAIL reset_ctrl inst%0d: got ack=%b err=%b busy=%b we=%b stb=%b cyc=%b expected all 0",
                         d, ack_o[d], err_o[d], busy[d], wb_we[d], wb_stb[d], wb_cyc[d]);
            end
            checks++;
            if ({wb_adr[d], wb_dat[d], rdata[d], wb_sel[d]} !== '0) begin
                failures++;
                $display("FAIL reset_data inst%0d: got adr=%h dat=%h rdata=%h sel=%h expected 0",
                         d, wb_adr[d], wb_dat[d], rdata[d], wb_sel[d]);
            end
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        set_port(1, 1, 32'h0000_1000, 1'b0, '0);
        req[1] = 3'b010;
        tick();
        checks++;
        if (wb_stb[1] !== 1'b1 || wb_cyc[1] !== 1'b1 || wb_adr[1] !== 32'h1000 || busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL single_read_start: got stb=%b cyc=%b adr=%h busy=%b expected 1 1 00001000 1",
                     wb_stb[1], wb_cyc[1], wb_adr[1], busy[1]);
        end
        tick();
        checks++;
        if (wb_stb[1] !== 1'b1 || ack_o[1] !== 3'b000) begin
            failures++;
            $display("FAIL single_read_wait: got stb=%b ack=%b expected 1 000", wb_stb[1], ack_o[1]);
        end
        tick();
        wb_ack[1]    = 1'b1;
        wb_dat_in[1] = 32'hDEAD_BEEF;
        tick();
        wb_ack[1]    = 1'b0;
        wb_dat_in[1] = '0;
        req[1]       = 3'b000;
        checks++;
        if (ack_o[1] !== 3'b010 || rdata[1] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_read_ack: got ack=%b rdata=%h expected 010 deadbeef", ack_o[1], rdata[1]);
        end
        checks++;
        if (wb_cyc[1] !== 1'b0 || wb_stb[1] !== 1'b0) begin
            failures++;
            $display("FAIL single_read_release: got cyc=%b stb=%b expected 0 0", wb_cyc[1], wb_stb[1]);
        end
        tick();
        checks++;
        if (ack_o[1] !== 3'b000 || wb_cyc[1] !== 1'b0) begin
            failures++;
            $display("FAIL single_read_once: got ack=%b cyc=%b expected 000 0", ack_o[1], wb_cyc[1]);
        end
    endtask

    // Continuous requests from all ports; slave acks one cycle after stb.
    task automatic run_contention(input int d, input int n, input bit rr);
        bit ok;
        int exp_port;
        for (int k = 0; k < NP; k++) set_port(d, k, AW'(32'h100 * (k + 1)), 1'b0, '0);
        req[d] = 3'b111;
        for (int t = 0; t < n; t++) begin
            exp_port = rr ? (t % NP) : 0;
            wait_stb(d, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL contention_stb inst%0d xfer%0d: got no stb expected stb within 8 cycles", d, t);
            end
            checks++;
            if (wb_adr[d] !== AW'(32'h100 * (exp_port + 1))) begin
                failures++;
                $display("FAIL contention_grant inst%0d xfer%0d: got adr=%h expected %h",
                         d, t, wb_adr[d], 32'h100 * (exp_port + 1));
            end
            tick();
            wb_ack[d] = 1'b1;
            tick();
            wb_ack[d] = 1'b0;
            if (t == n - 1) req[d] = 3'b000;
            checks++;
            if (ack_o[d] !== NP'(1 << exp_port)) begin
                failures++;
                $display("FAIL contention_ack inst%0d xfer%0d: got ack=%b expected %b",
                         d, t, ack_o[d], NP'(1 << exp_port));
            end
        end
        tick();
    endtask

    task automatic test_fixed_priority();
        run_contention(0, 4, 1'b0);
    endtask

    task automatic test_round_robin();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        run_contention(1, 6, 1'b1);
    endtask

    task automatic test_timeout();
        set_port(0, 2, 32'h0000_2000, 1'b0, '0);
        req[0] = 3'b100;
        tick();
        checks++;
        if (wb_stb[0] !== 1'b1) begin
            failures++;
            $display("FAIL timeout_start: got stb=%b expected 1", wb_stb[0]);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (err_o[0] !== 3'b000 || wb_cyc[0] !== 1'b1) begin
                failures++;
                $display("FAIL timeout_early cycle%0d: got err=%b cyc=%b expected 000 1", i, err_o[0], wb_cyc[0]);
            end
        end
        tick();
        req[0] = 3'b000;
        checks++;
        if (err_o[0] !== 3'b100 || ack_o[0] !== 3'b000 || rdata[0] !== 32'h0 || wb_cyc[0] !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err: got err=%b ack=%b rdata=%h cyc=%b expected 100 000 0 0",
                     err_o[0], ack_o[0], rdata[0], wb_cyc[0]);
        end
        wb_ack[0]    = 1'b1;
        wb_dat_in[0] = 32'hBAD0_BAD0;
        tick();
        wb_ack[0]    = 1'b0;
        checks++;
        if (ack_o[0] !== 3'b000 || err_o[0] !== 3'b000 || wb_cyc[0] !== 1'b0) begin
            failures++;
            $display("FAIL timeout_late_ack: got ack=%b err=%b cyc=%b expected 000 000 0",
                     ack_o[0], err_o[0], wb_cyc[0]);
        end
        set_port(0, 1, 32'h0000_3000, 1'b0, '0);
        req[0] = 3'b010;
        tick();
        wb_ack[0]    = 1'b1;
        wb_dat_in[0] = 32'h1234_5678;
        tick();
        wb_ack[0] = 1'b0;
        req[0]    = 3'b000;
        checks++;
        if (ack_o[0] !== 3'b010 || rdata[0] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL timeout_recover: got ack=%b rdata=%h expected 010 12345678", ack_o[0], rdata[0]);
        end
        tick();
    endtask

    task automatic test_lock();
        set_port(0, 0, 32'h0000_0010, 1'b0, '0);
        set_port(0, 1, 32'h0000_3000, 1'b0, '0);
        lock[0] = 3'b001;
        req[0]  = 3'b011;
        tick();
        checks++;
        if (wb_stb[0] !== 1'b1 || wb_adr[0] !== 32'h10) begin
            failures++;
            $display("FAIL lock_first: got stb=%b adr=%h expected 1 00000010", wb_stb[0], wb_adr[0]);
        end
        tick();
        wb_ack[0]    = 1'b1;
        wb_dat_in[0] = 32'hA5A5_A5A5;
        tick();
        wb_ack[0] = 1'b0;
        req[0]    = 3'b010;
        set_port(0, 0, 32'h0000_0020, 1'b1, 32'hCAFE_F00D);
        checks++;
        if (ack_o[0] !== 3'b001 || rdata[0] !== 32'hA5A5_A5A5 || wb_cyc[0] !== 1'b1 || wb_stb[0] !== 1'b0) begin
            failures++;
            $display("FAIL lock_read_ack: got ack=%b rdata=%h cyc=%b stb=%b expected 001 a5a5a5a5 1 0",
                     ack_o[0], rdata[0], wb_cyc[0], wb_stb[0]);
        end
        tick();
        checks++;
        if (wb_cyc[0] !== 1'b1 || wb_stb[0] !== 1'b0 || wb_adr[0] === 32'h3000) begin
            failures++;
            $display("FAIL lock_hold: got cyc=%b stb=%b adr=%h expected 1 0 and not port1",
                     wb_cyc[0], wb_stb[0], wb_adr[0]);
        end
        req[0] = 3'b011;
        tick();
        checks++;
        if (wb_stb[0] !== 1'b1 || wb_adr[0] !== 32'h20 || wb_we[0] !== 1'b1 || wb_dat[0] !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL lock_write: got stb=%b adr=%h we=%b dat=%h expected 1 00000020 1 cafef00d",
                     wb_stb[0], wb_adr[0], wb_we[0], wb_dat[0]);
        end
        wb_ack[0] = 1'b1;
        tick();
        wb_ack[0] = 1'b0;
        req[0]    = 3'b010;
        lock[0]   = 3'b000;
        checks++;
        if (ack_o[0] !== 3'b001 || wb_cyc[0] !== 1'b1) begin
            failures++;
            $display("FAIL lock_write_ack: got ack=%b cyc=%b expected 001 1", ack_o[0], wb_cyc[0]);
        end
        tick();
        checks++;
        if (wb_cyc[0] !== 1'b0 || wb_stb[0] !== 1'b0) begin
            failures++;
            $display("FAIL lock_release: got cyc=%b stb=%b expected 0 0", wb_cyc[0], wb_stb[0]);
        end
        tick();
        checks++;
        if (wb_stb[0] !== 1'b1 || wb_adr[0] !== 32'h3000 || wb_we[0] !== 1'b0) begin
            failures++;
            $display("FAIL lock_port1_grant: got stb=%b adr=%h we=%b expected 1 00003000 0",
                     wb_stb[0], wb_adr[0], wb_we[0]);
        end
        wb_ack[0] = 1'b1;
        tick();
        wb_ack[0] = 1'b0;
        req[0]    = 3'b000;
        checks++;
        if (ack_o[0] !== 3'b010) begin
            failures++;
            $display("FAIL lock_port1_ack: got ack=%b expected 010", ack_o[0]);
        end
        tick();
    endtask

    task automatic test_err();
        set_port(0, 2, 32'h0000_0040, 1'b0, '0);
        req[0] = 3'b100;
        tick();
        wb_ack[0]    = 1'b1;
        wb_err[0]    = 1'b1;
        wb_dat_in[0] = 32'h0000_0055;
        tick();
        wb_ack[0] = 1'b0;
        wb_err[0] = 1'b0;
        req[0]    = 3'b000;
        checks++;
        if (ack_o[0] !== 3'b100 || err_o[0] !== 3'b000 || rdata[0] !== 32'h55) begin
            failures++;
            $display("FAIL err_with_ack: got ack=%b err=%b rdata=%h expected 100 000 00000055",
                     ack_o[0], err_o[0], rdata[0]);
        end
        tick();
        set_port(0, 1, 32'h0000_0044, 1'b1, 32'h0000_0099);
        req[0] = 3'b010;
        tick();
        checks++;
        if (wb_stb[0] !== 1'b1 || wb_we[0] !== 1'b1 || wb_dat[0] !== 32'h99 || wb_sel[0] !== 4'hF) begin
            failures++;
            $display("FAIL err_write_start: got stb=%b we=%b dat=%h sel=%h expected 1 1 00000099 f",
                     wb_stb[0], wb_we[0], wb_dat[0], wb_sel[0]);
        end
        wb_err[0]    = 1'b1;
        wb_dat_in[0] = 32'hFFFF_FFFF;
        tick();
        wb_err[0] = 1'b0;
        req[0]    = 3'b000;
        checks++;
        if (err_o[0] !== 3'b010 || ack_o[0] !== 3'b000 || rdata[0] !== 32'h0) begin
            failures++;
            $display("FAIL err_alone: got err=%b ack=%b rdata=%h expected 010 000 0",
                     err_o[0], ack_o[0], rdata[0]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        set_port(1, 0, 32'h0000_0500, 1'b0, '0);
        req[1] = 3'b001;
        tick();
        checks++;
        if (wb_stb[1] !== 1'b1 || wb_adr[1] !== 32'h500) begin
            failures++;
            $display("FAIL reset_mid_start: got stb=%b adr=%h expected 1 00000500", wb_stb[1], wb_adr[1]);
        end
        tick();
        rst[1]       = 1'b1;
        wb_ack[1]    = 1'b1;
        wb_dat_in[1] = 32'h0000_0077;
        tick();
        checks++;
        if ({ack_o[1], err_o[1], busy[1], wb_stb[1], wb_cyc[1]} !== 9'b0 || wb_adr[1] !== '0 || rdata[1] !== '0) begin
            failures++;
            $display("FAIL reset_mid_clear: got ack=%b err=%b busy=%b stb=%b cyc=%b adr=%h rdata=%h expected all 0",
                     ack_o[1], err_o[1], busy[1], wb_stb[1], wb_cyc[1], wb_adr[1], rdata[1]);
        end
        rst[1]    = 1'b0;
        wb_ack[1] = 1'b0;
        req[1]    = 3'b000;
        tick();
        checks++;
        if (ack_o[1] !== 3'b000 || err_o[1] !== 3'b000 || wb_cyc[1] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_quiet: got ack=%b err=%b cyc=%b expected 000 000 0",
                     ack_o[1], err_o[1], wb_cyc[1]);
        end
        set_port(1, 0, 32'h0000_0600, 1'b0, '0);
        set_port(1, 1, 32'h0000_0700, 1'b0, '0);
        req[1] = 3'b011;
        tick();
        checks++;
        if (wb_stb[1] !== 1'b1 || wb_adr[1] !== 32'h600) begin
            failures++;
            $display("FAIL reset_mid_rr_first: got stb=%b adr=%h expected 1 00000600", wb_stb[1], wb_adr[1]);
        end
        wb_ack[1] = 1'b1;
        tick();
        wb_ack[1] = 1'b0;
        req[1]    = 3'b000;
        checks++;
        if (ack_o[1] !== 3'b001) begin
            failures++;
            $display("FAIL reset_mid_rr_ack: got ack=%b expected 001", ack_o[1]);
        end
        tick();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b0;
            req[d]       = '0;
            lock[d]      = '0;
            we[d]        = '0;
            addr[d]      = '0;
            wdata[d]     = '0;
            sel[d]       = '0;
            wb_dat_in[d] = '0;
            wb_ack[d]    = 1'b0;
            wb_err[d]    = 1'b0;
        end
        #1;
        test_reset();
        test_single_read();
        test_fixed_priority();
        test_round_robin();
        test_timeout();
        test_lock();
        test_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
